// File: rtl/psram_resp_if.sv
// Octal PSRAM pin bundle between the controller (master) and the device-side responder (slave).
interface psram_resp_if;
  logic       psram_sck;
  logic       psram_ce;
  logic [7:0] psram_io_in;
  logic [7:0] psram_io_out;
  logic [7:0] psram_io_en;
  logic       psram_dqs_out;
  logic       psram_dqs_en;

  modport master (
    output psram_sck, psram_ce, psram_io_in,
    input  psram_io_out, psram_io_en, psram_dqs_out, psram_dqs_en
  );

  modport slave (
    input  psram_sck, psram_ce, psram_io_in,
    output psram_io_out, psram_io_en, psram_dqs_out, psram_dqs_en
  );
endinterface

// File: rtl/psram_resp.sv
// Device-side octal PSRAM responder: oversamples the SDR pins, decodes inst/addr/latency/data, serves a byte array.
// Defining PSRAM_RESP_GRST_EN adds the opcode 8'hFF global-clear command and a live busy_o.
module psram_resp #(
  parameter int MEM_DEPTH   = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  cfg_wcmd_i,
  input  logic [7:0]  cfg_rcmd_i,
  input  logic [7:0]  cfg_wlc_i,
  input  logic [7:0]  cfg_rlc_i,
  psram_resp_if.slave psram,
  output logic        xfer_done_o,
  output logic        xfer_err_o,
  output logic        busy_o
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_INST, S_ADDR, S_LATN, S_WDATA, S_RDATA, S_ERR
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ce_sync;
  logic [7:0]             r_io_sync [SYNC_STAGES];
  logic                   r_sck_d;

  logic       w_sck, w_ce_n, w_rise, w_fall;
  logic [7:0] w_io;

  logic          r_rd;
  logic [31:0]   r_addr;
  logic [1:0]    r_addr_cnt;
  logic [7:0]    r_lat_cnt;
  logic [AW-1:0] r_ptr;
  logic          r_beat_seen;
  logic [7:0]    r_io_out;
  logic          r_dqs_out;
  logic          r_oe;
  logic          r_done;
  logic          r_err;
  logic [7:0]    r_mem [MEM_DEPTH];

  logic        w_is_rd, w_is_wr, w_is_grst, w_known;
  logic [7:0]  w_lat_load;
  logic [31:0] w_addr_nxt;
  state_t      w_data_st;
  logic        w_busy;
  logic        w_done, w_err, w_we, w_rbeat;
  logic        w_unused;

  // sck, ce and io share one synchronizer depth so their relative timing is preserved
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sck_sync <= '0;
      r_ce_sync  <= '1;
      r_sck_d    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) r_io_sync[i] <= 8'h00;
    end else begin
      r_sck_sync[0] <= psram.psram_sck;
      r_ce_sync[0]  <= psram.psram_ce;
      r_io_sync[0]  <= psram.psram_io_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sck_sync[i] <= r_sck_sync[i-1];
        r_ce_sync[i]  <= r_ce_sync[i-1];
        r_io_sync[i]  <= r_io_sync[i-1];
      end
      r_sck_d <= w_sck;
    end
  end

  assign w_sck  = r_sck_sync[SYNC_STAGES-1];
  assign w_ce_n = r_ce_sync[SYNC_STAGES-1];
  assign w_io   = r_io_sync[SYNC_STAGES-1];
  assign w_rise = w_sck & ~r_sck_d;
  assign w_fall = ~w_sck & r_sck_d;

  assign w_is_rd    = (w_io == cfg_rcmd_i);
  assign w_is_wr    = (w_io == cfg_wcmd_i);
  assign w_known    = (w_is_rd | w_is_wr) & ~w_is_grst;
  assign w_lat_load = r_rd ? cfg_rlc_i : cfg_wlc_i;
  assign w_addr_nxt = {r_addr[23:0], w_io};
  assign w_data_st  = r_rd ? S_RDATA : S_WDATA;
  assign w_unused   = ^r_addr[31:24];

`ifdef PSRAM_RESP_GRST_EN
  logic          r_grst_pend;
  logic          r_busy;
  logic [AW-1:0] r_clr_ptr;
  logic          w_grst_set;

  assign w_is_grst  = (w_io == 8'hFF);
  assign w_grst_set = (r_state == S_INST) && !w_ce_n && w_rise && w_is_grst;
  assign w_busy     = r_busy;

  // Clear starts only once the host releases CE after the command
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_grst_pend <= 1'b0;
      r_busy      <= 1'b0;
      r_clr_ptr   <= '0;
    end else if (w_grst_set) begin
      r_grst_pend <= 1'b1;
    end else if (r_grst_pend && (r_state == S_ERR) && w_ce_n) begin
      r_grst_pend <= 1'b0;
      r_busy      <= 1'b1;
      r_clr_ptr   <= '0;
    end else if (r_busy) begin
      r_clr_ptr <= r_clr_ptr + PTR_ONE;
      if (r_clr_ptr == {AW{1'b1}}) r_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (r_busy) r_mem[r_clr_ptr] <= 8'h00;
    else if (w_we) r_mem[r_ptr] <= w_io;
  end
`else
  assign w_is_grst = 1'b0;
  assign w_busy    = 1'b0;

  always_ff @(posedge clk_i) begin
    if (w_we) r_mem[r_ptr] <= w_io;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // CE release beats any same-cycle rise from every non-idle state
  always_comb begin
    w_state_nxt = r_state;
    if ((r_state != S_IDLE) && w_ce_n) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (!w_ce_n && !w_busy) w_state_nxt = S_INST;
        S_INST: if (w_rise) w_state_nxt = w_known ? S_ADDR : S_ERR;
        S_ADDR: if (w_rise && (r_addr_cnt == 2'd3))
                  w_state_nxt = (w_lat_load == 8'd0) ? w_data_st : S_LATN;
        S_LATN: if (w_rise && (r_lat_cnt == 8'd1)) w_state_nxt = w_data_st;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_done  = 1'b0;
    w_err   = 1'b0;
    w_we    = 1'b0;
    w_rbeat = 1'b0;
    case (r_state)
      S_INST:  w_err = w_ce_n | (w_rise & ~w_known & ~w_is_grst);
      S_ADDR,
      S_LATN:  w_err = w_ce_n;
      S_WDATA: begin
        w_done = w_ce_n & r_beat_seen;
        w_err  = w_ce_n & ~r_beat_seen;
        w_we   = ~w_ce_n & w_rise;
      end
      S_RDATA: begin
        w_done  = w_ce_n & r_beat_seen;
        w_err   = w_ce_n & ~r_beat_seen;
        w_rbeat = ~w_ce_n & w_fall;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd        <= 1'b0;
      r_addr      <= 32'h0;
      r_addr_cnt  <= 2'd0;
      r_lat_cnt   <= 8'd0;
      r_ptr       <= '0;
      r_beat_seen <= 1'b0;
      r_io_out    <= 8'h00;
      r_dqs_out   <= 1'b0;
      r_oe        <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= w_done;
      r_err  <= w_err;
      if (w_state_nxt == S_IDLE) begin
        r_addr_cnt  <= 2'd0;
        r_beat_seen <= 1'b0;
      end
      if ((r_state == S_INST) && !w_ce_n && w_rise) r_rd <= w_is_rd;
      if ((r_state == S_ADDR) && !w_ce_n && w_rise) begin
        r_addr     <= w_addr_nxt;
        r_addr_cnt <= r_addr_cnt + 2'd1;
        if (r_addr_cnt == 2'd3) begin
          r_lat_cnt <= w_lat_load;
          r_ptr     <= w_addr_nxt[AW-1:0];
        end
      end
      if ((r_state == S_LATN) && !w_ce_n && w_rise) r_lat_cnt <= r_lat_cnt - 8'd1;
      if (w_we) begin
        r_ptr       <= r_ptr + PTR_ONE;
        r_beat_seen <= 1'b1;
      end
      if (w_rbeat) begin
        r_io_out    <= r_mem[r_ptr];
        r_ptr       <= r_ptr + PTR_ONE;
        r_dqs_out   <= ~r_dqs_out;
        r_beat_seen <= 1'b1;
      end else if ((r_state != S_RDATA) && (w_state_nxt == S_RDATA)) begin
        r_dqs_out <= 1'b0;
      end
      r_oe <= (w_state_nxt == S_RDATA) && (r_oe || w_rbeat);
    end
  end

  assign psram.psram_io_out  = r_io_out;
  assign psram.psram_io_en   = {8{r_oe}};
  assign psram.psram_dqs_out = r_dqs_out;
  assign psram.psram_dqs_en  = r_oe;
  assign xfer_done_o         = r_done;
  assign xfer_err_o          = r_err;
  assign busy_o              = w_busy;
endmodule

// File: tb/tb_psram_resp.sv
// Self-checking bench for psram_resp: table of write/read transfers plus hand-written corner sequences.
module tb_psram_resp;
  localparam int MEM_DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cfgWcmd, cfgRcmd, cfgWlc, cfgRlc;
  logic       xferDone, xferErr, busy;

  psram_resp_if psram();

  psram_resp #(.MEM_DEPTH(MEM_DEPTH), .SYNC_STAGES(2)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .cfg_wcmd_i  (cfgWcmd),
    .cfg_rcmd_i  (cfgRcmd),
    .cfg_wlc_i   (cfgWlc),
    .cfg_rlc_i   (cfgRlc),
    .psram       (psram),
    .xfer_done_o (xferDone),
    .xfer_err_o  (xferErr),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    int          lat;
    int          n;
    logic [31:0] bytes;
    int          expDone;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  logic [7:0] expQ[$];

  // Monitor: a dqs toggle while the strobe is enabled is one read beat
  logic [7:0] obsMem [1024];
  int         obsWr = 0;
  int         doneCnt = 0;
  int         errCnt = 0;
  int         enHigh = 0;
  logic       prevDqs = 1'b0;

  always @(negedge clk) begin
    if (psram.psram_dqs_en && (psram.psram_dqs_out != prevDqs)) begin
      obsMem[obsWr % 1024] <= psram.psram_io_out;
      obsWr <= obsWr + 1;
    end
    prevDqs <= psram.psram_dqs_out;
    if (xferDone) doneCnt <= doneCnt + 1;
    if (xferErr) errCnt <= errCnt + 1;
    if (psram.psram_io_en != 8'h00) enHigh <= enHigh + 1;
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  // One SDR beat: data set while sck low, sampled on the rise, beat closes with a fall
  task automatic driveBeat(input logic [7:0] b);
    psram.psram_io_in = b;
    waitClk(4);
    psram.psram_sck = 1'b1;
    waitClk(4);
    psram.psram_sck = 1'b0;
  endtask

  task automatic scoreboardCheck(input string name, input int obsW0, input int nExp);
    int nObs;
    nObs = obsWr - obsW0;
    checkOutput({name, " beats"}, nObs, nExp);
    for (int i = 0; i < nObs; i++) begin
      if (expQ.size() > 0)
        checkOutput($sformatf("%s byte%0d", name, i), obsMem[(obsW0 + i) % 1024], expQ.pop_front());
    end
    expQ.delete();
  endtask

  // Full CE window; a read's first byte arrives on the fall of the last address/dummy beat
  task automatic applyStimulus(input string name, input logic [7:0] op, input logic [31:0] addr,
                               input int nAddr, input int lat, input logic rd, input int n,
                               input logic [31:0] bytes, input int expDone, input int expErr);
    int d0, e0, o0;
    d0 = doneCnt;
    e0 = errCnt;
    o0 = obsWr;
    cfgWlc = 8'(lat);
    cfgRlc = 8'(lat);
    psram.psram_ce = 1'b0;
    waitClk(8);
    driveBeat(op);
    if (rd) for (int i = 0; i < n; i++) expQ.push_back(bytes[31-8*i -: 8]);
    for (int i = 0; i < nAddr; i++) driveBeat(addr[31-8*i -: 8]);
    for (int i = 0; i < lat; i++) driveBeat(8'h00);
    if (rd) begin
      for (int i = 1; i < n; i++) driveBeat(8'h00);
    end else begin
      for (int i = 0; i < n; i++) driveBeat(bytes[31-8*i -: 8]);
    end
    waitClk(4);
    psram.psram_ce = 1'b1;
    waitClk(10);
    scoreboardCheck(name, o0, rd ? n : 0);
    checkOutput({name, " done"}, doneCnt - d0, expDone);
    checkOutput({name, " err"}, errCnt - e0, expErr);
  endtask

  initial begin
    vec_t vecs[7];
    int   en0, o0, busyCyc, waited;

    vecs[0] = '{1'b0, 32'h0000_0010, 2, 3, 32'hA55A3C00, 1};
    vecs[1] = '{1'b1, 32'h0000_0010, 4, 3, 32'hA55A3C00, 1};
    vecs[2] = '{1'b0, 32'(MEM_DEPTH-2), 1, 4, 32'h11223344, 1};
    vecs[3] = '{1'b1, 32'h0000_0000, 3, 2, 32'h33440000, 1};
    vecs[4] = '{1'b1, 32'(MEM_DEPTH-2), 2, 4, 32'h11223344, 1};
    vecs[5] = '{1'b1, 32'hABCD_FFFF, 0, 1, 32'h22000000, 1};
    vecs[6] = '{1'b1, 32'h0000_0011, 0, 2, 32'h5A3C0000, 1};

    cfgWcmd = 8'h80;
    cfgRcmd = 8'h00;
    cfgWlc  = 8'd0;
    cfgRlc  = 8'd0;
    psram.psram_sck   = 1'b0;
    psram.psram_ce    = 1'b1;
    psram.psram_io_in = 8'h00;
    rst_n = 1'b0;
    waitClk(3);
    checkOutput("reset io_en", psram.psram_io_en, 8'h00);
    checkOutput("reset dqs_en", psram.psram_dqs_en, 1'b0);
    checkOutput("reset io_out", psram.psram_io_out, 8'h00);
    checkOutput("reset flags", {xferDone, xferErr, busy}, 3'b000);
    rst_n = 1'b1;
    waitClk(4);

    for (int i = 0; i < 7; i++)
      applyStimulus($sformatf("vec%0d", i), vecs[i].rd ? cfgRcmd : cfgWcmd, vecs[i].addr, 4,
                    vecs[i].lat, vecs[i].rd, vecs[i].n, vecs[i].bytes, vecs[i].expDone, 0);

    en0 = enHigh;
    applyStimulus("badop", 8'h55, 32'h0000_0010, 4, 0, 1'b0, 2, 32'hDEAD0000, 0, 1);
    checkOutput("badop io_en cycles", enHigh - en0, 0);
    applyStimulus("badop readback", cfgRcmd, 32'h0000_0010, 4, 0, 1'b1, 2, 32'hA55A0000, 1, 0);

    applyStimulus("abort addr", cfgWcmd, 32'h0000_0020, 2, 0, 1'b0, 0, 32'h0, 0, 1);
    applyStimulus("post-abort wr", cfgWcmd, 32'h0000_0020, 4, 0, 1'b0, 2, 32'h77880000, 1, 0);
    applyStimulus("post-abort rd", cfgRcmd, 32'h0000_0020, 4, 1, 1'b1, 2, 32'h77880000, 1, 0);

    applyStimulus("zero beats", cfgWcmd, 32'h0000_0030, 4, 1, 1'b0, 0, 32'h0, 0, 1);

    cfgWcmd = 8'h00;
    applyStimulus("rd wins", 8'h00, 32'h0000_0010, 4, 1, 1'b1, 1, 32'hA5000000, 1, 0);
    cfgWcmd = 8'h80;

    // Reset in the middle of a read burst
    o0 = obsWr;
    cfgRlc = 8'd0;
    psram.psram_ce = 1'b0;
    waitClk(8);
    driveBeat(cfgRcmd);
    expQ.push_back(8'hA5);
    driveBeat(8'h00); driveBeat(8'h00); driveBeat(8'h00); driveBeat(8'h10);
    waitClk(4);
    checkOutput("pre-reset io_en", psram.psram_io_en, 8'hFF);
    rst_n = 1'b0;
    #1;
    checkOutput("mid-reset io_en", psram.psram_io_en, 8'h00);
    checkOutput("mid-reset dqs", {psram.psram_dqs_en, psram.psram_dqs_out}, 2'b00);
    checkOutput("mid-reset io_out", psram.psram_io_out, 8'h00);
    psram.psram_ce = 1'b1;
    waitClk(4);
    rst_n = 1'b1;
    waitClk(4);
    scoreboardCheck("reset rd", o0, 1);
    applyStimulus("retained", cfgRcmd, 32'h0000_0010, 4, 2, 1'b1, 3, 32'hA55A3C00, 1, 0);

`ifdef PSRAM_RESP_GRST_EN
    en0 = errCnt;
    psram.psram_ce = 1'b0;
    waitClk(8);
    driveBeat(8'hFF);
    waitClk(4);
    psram.psram_ce = 1'b1;
    waited = 0;
    while (!busy && waited < 50) begin
      waitClk(1);
      waited++;
    end
    busyCyc = 0;
    while (busy && busyCyc < 2000) begin
      waitClk(1);
      busyCyc++;
    end
    checkOutput("grst busy cycles", busyCyc, MEM_DEPTH);
    checkOutput("grst err", errCnt - en0, 0);
    applyStimulus("grst rd hi", cfgRcmd, 32'(MEM_DEPTH-2), 4, 0, 1'b1, 4, 32'h0, 1, 0);
    applyStimulus("grst rd mid", cfgRcmd, 32'h0000_0010, 4, 0, 1'b1, 3, 32'h0, 1, 0);
`else
    busyCyc = 0;
    waited  = 0;
    applyStimulus("ff opcode", 8'hFF, 32'h0000_0010, 4, 0, 1'b0, 1, 32'h99000000, 0, 1);
    checkOutput("busy tied", {31'(busyCyc + waited), busy}, 32'h0);
    applyStimulus("ff readback", cfgRcmd, 32'h0000_0010, 4, 0, 1'b1, 1, 32'hA5000000, 1, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/psram_resp.md
Name: psram_resp

Overview:
- Behavioural-synthesizable PSRAM device-side responder: the far end of the octal PSRAM pin interface driven by the PSRAM controller core.
- Oversamples the PSRAM pins with the fast internal clock, then decodes instruction, address, latency and data phases.
- Services reads and writes from an internal byte array.
- Used as the loop-back target in the PSRAM subsystem testbench and as an on-chip scratch PSRAM stand-in.

Parameters:
- MEM_DEPTH, 256, number of bytes in the internal array; must be a power of two, at least 16.
- SYNC_STAGES, 2, synchronizer depth applied identically to sck, ce and io.

Ports:
- clk_i  in  1  internal clock; at least 4x the PSRAM sck frequency.
- rst_n_i  in  1  reset, asynchronous, active-low.
- cfg_wcmd_i  in  8  write instruction opcode.
- cfg_rcmd_i  in  8  read instruction opcode.
- cfg_wlc_i  in  8  write latency, in sck beats.
- cfg_rlc_i  in  8  read latency, in sck beats.
- psram_sck_i  in  1  PSRAM clock from the controller.
- psram_ce_i  in  1  chip enable, active-low.
- psram_io_in_i  in  8  octal data from the controller.
- psram_io_out_o  out  8  octal read data.
- psram_io_en_o  out  8  per-bit output enable.
- psram_dqs_out_o  out  1  read data strobe.
- psram_dqs_en_o  out  1  strobe output enable.
- xfer_done_o  out  1  one-cycle pulse at the end of a completed data transfer.
- xfer_err_o  out  1  one-cycle pulse on an unknown opcode or an aborted transfer.
- busy_o  out  1  high while a global reset clear is in progress (optional feature only).

Behaviour:
- Clocking and reset:
  - Single clock clk_i; asynchronous active-low reset rst_n_i.
  - Reset values: all outputs 0, FSM in IDLE, counters 0. Array contents are not reset.
- Input sampling:
  - sck, ce and io each pass through SYNC_STAGES flops, so the three stay mutually aligned.
  - rise = synced sck 0->1; fall = synced sck 1->0; ce_n = synced ce.
- Bus protocol is SDR:
  - Controller drives io, device samples it on rise.
  - Device drives io and changes it on fall.
- FSM states: IDLE, INST, ADDR, LATN, WDATA, RDATA, ERR.
- IDLE: on ce_n==0 -> INST.
- INST, on the first rise:
  - Latch opcode from io.
  - opcode==cfg_rcmd_i -> ADDR with rd=1.
  - opcode==cfg_wcmd_i -> ADDR with rd=0.
  - Any other opcode -> ERR, with an xfer_err_o pulse.
  - If rcmd==wcmd, read wins.
- ADDR:
  - 4 rises, MSB byte first, shifted into a 32-bit register.
  - Only the low log2(MEM_DEPTH) bits are used as the byte pointer.
  - After the 4th rise: load lat_cnt = rd ? cfg_rlc_i : cfg_wlc_i. lat_cnt==0 goes straight to the data state; otherwise -> LATN.
- LATN:
  - Each rise decrements lat_cnt.
  - The rise that makes it 0 moves to RDATA or WDATA.
  - Exactly cfg_*lc_i dummy beats.
- WDATA:
  - Each rise writes io to mem[ptr], then ptr <= ptr+1.
  - ptr wraps modulo MEM_DEPTH; bursts are unlimited.
- RDATA:
  - Each fall drives io_out = mem[ptr], then ptr+1 (same wrap), and toggles dqs_out.
  - dqs_out is cleared to 0 on entry to RDATA.
  - io_en = 8'hFF and dqs_en = 1 only while in RDATA with ce_n==0. The first fall in RDATA enables them.
  - Outputs are held between falls.
- ERR: ignore the bus until ce_n==1.
- CE deassert (ce_n 0->1):
  - From any state: return to IDLE next clk, all enables to 0.
  - If in WDATA/RDATA with at least 1 data beat completed: xfer_done_o pulses 1 cycle.
  - If in INST/ADDR/LATN, or in a data state with zero beats: xfer_err_o pulses 1 cycle.
  - A rise and a CE deassert in the same clk: the CE deassert wins; the beat is discarded.
- A write and a read to the same ptr cannot occur in one cycle (single transfer direction).
- Reset asserted mid-transfer:
  - Outputs go to 0 immediately; FSM goes to IDLE.
  - Array bytes already written are retained.
- Latency from pin rise to internal action: SYNC_STAGES+1 clk.

Optional Feature:
- Macro PSRAM_RESP_GRST_EN.
- Defined:
  - Opcode 8'hFF is the global reset command, accepted in INST with no address phase.
  - It waits for ce_n==1, then busy_o=1 and mem[0..MEM_DEPTH-1] are cleared to 0, one byte per clk.
  - busy_o drops after MEM_DEPTH cycles.
  - Any ce_n==0 while busy is ignored; the FSM stays in IDLE until busy_o=0.
- Not defined:
  - 8'hFF is an ordinary unknown opcode (ERR path, xfer_err_o pulse).
  - busy_o is tied to 0.

Test Plan:
- Write then read back:
  - Stimulus: wcmd=0x80, wlc=2, addr 0x00000010, data A5 5A 3C.
  - Stimulus: rcmd=0x00, rlc=4, same addr, 3 beats.
  - Required: io_out sequence A5, 5A, 3C; dqs toggles 3 times; xfer_done_o pulses twice.
- Wrap-around:
  - Stimulus: write 4 bytes at addr MEM_DEPTH-2.
  - Required: bytes land at 254, 255, 0, 1 (MEM_DEPTH=256); read from 254 returns the same bytes.
- Zero latency:
  - Stimulus: rlc=0.
  - Required: the first byte is driven on the fall right after the 4th address rise.
- Unknown opcode:
  - Stimulus: opcode 0x55.
  - Required: xfer_err_o pulse; io_en stays 0 for the whole CE window; no memory change.
- Abort in ADDR:
  - Stimulus: CE rises after 2 address beats.
  - Required: xfer_err_o pulse, FSM back to IDLE; the next valid write succeeds.
- Optional feature, with PSRAM_RESP_GRST_EN:
  - Stimulus: opcode 0xFF, then CE high.
  - Required: busy_o high for 256 clk; all bytes read back as 0x00.
